// File: rtl/alarm_ringer.sv
// Alarm ringer: compares running time against the stored alarm time and runs the ring/snooze FSM.
// Optional feature: define ALARM_TONE_EN to gate the buzzer with a square-wave tone of TONE_DIV-cycle half-periods.
module alarm_ringer #(
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int TONE_DIV         = 25000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       alarm_en,
    input  logic       snooze,
    input  logic       stop,
    input  logic [3:0] time_hourMSB,
    input  logic [3:0] time_hourLSB,
    input  logic [3:0] time_minMSB,
    input  logic [3:0] time_minLSB,
    input  logic [3:0] time_secMSB,
    input  logic [3:0] time_secLSB,
    input  logic [3:0] alarm_hourMSB,
    input  logic [3:0] alarm_hourLSB,
    input  logic [3:0] alarm_minMSB,
    input  logic [3:0] alarm_minLSB,
    input  logic [3:0] alarm_secMSB,
    input  logic [3:0] alarm_secLSB,
    output logic       buzz,
    output logic       ringing,
    output logic       snoozing,
    output logic [8:0] snooze_left
);

    // Reject out-of-range configurations at elaboration rather than letting the counters truncate.
    if (SNOOZE_SEC < 1 || SNOOZE_SEC > 511) begin : g_bad_snooze_sec
        $error("alarm_ringer: SNOOZE_SEC must be 1..511");
    end
    if (RING_TIMEOUT_SEC < 1 || RING_TIMEOUT_SEC > 255) begin : g_bad_ring_timeout
        $error("alarm_ringer: RING_TIMEOUT_SEC must be 1..255");
    end
    if (TONE_DIV < 1) begin : g_bad_tone_div
        $error("alarm_ringer: TONE_DIV must be at least 1");
    end

    localparam logic [8:0] SNOOZE_INIT = 9'(SNOOZE_SEC);
    localparam logic [7:0] RING_LAST   = 8'(RING_TIMEOUT_SEC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] ring_cnt;
    logic       match;
    logic       match_q;
    logic       match_rise;

    assign match = {time_hourMSB, time_hourLSB, time_minMSB, time_minLSB, time_secMSB, time_secLSB}
                == {alarm_hourMSB, alarm_hourLSB, alarm_minMSB, alarm_minLSB, alarm_secMSB, alarm_secLSB};
    assign match_rise = match & ~match_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ring_cnt    <= '0;
            snooze_left <= '0;
            match_q     <= 1'b1;  // an equality present at reset release must not look like a new match
        end else begin
            match_q <= match;
            unique case (state)
                IDLE: begin
                    snooze_left <= '0;
                    if (match_rise && alarm_en) begin
                        state    <= RINGING;
                        ring_cnt <= '0;
                    end
                end
                RINGING: begin
                    if (stop || !alarm_en) begin
                        state       <= IDLE;
                        snooze_left <= '0;
                    end else if (snooze) begin
                        state       <= SNOOZE;
                        snooze_left <= SNOOZE_INIT;
                    end else if (tick_1hz) begin
                        if (ring_cnt == RING_LAST) begin
                            state       <= IDLE;
                            snooze_left <= '0;
                        end else begin
                            ring_cnt <= ring_cnt + 8'd1;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop || !alarm_en) begin
                        state       <= IDLE;
                        snooze_left <= '0;
                    end else if (tick_1hz) begin
                        if (snooze_left == 9'd1) begin
                            state       <= RINGING;
                            ring_cnt    <= '0;
                            snooze_left <= '0;
                        end else begin
                            snooze_left <= snooze_left - 9'd1;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    snooze_left <= '0;
                end
            endcase
        end
    end

    assign ringing  = (state == RINGING);
    assign snoozing = (state == SNOOZE);

`ifdef ALARM_TONE_EN
    localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);

    logic [TONE_W-1:0] tone_cnt;
    logic              tone;

    // Tone restarts from silence on every entry to RINGING.
    always_ff @(posedge clk) begin
        if (reset || state != RINGING) begin
            tone_cnt <= '0;
            tone     <= 1'b0;
        end else if (tone_cnt == TONE_LAST) begin
            tone_cnt <= '0;
            tone     <= ~tone;
        end else begin
            tone_cnt <= tone_cnt + 1'b1;
        end
    end

    assign buzz = ringing & tone;
`else
    assign buzz = ringing;
`endif

endmodule

// File: doc/alarm_ringer.md
# alarm_ringer

Consumer side of the alarm-setting counter: samples the six BCD digits of the running clock and the six BCD digits of the stored alarm time, and rings when they match. Runs a ring/snooze state machine with a seconds-based snooze countdown and an automatic ring timeout. Drives the buzzer and status LEDs in the alarm-clock top level.

## Interface
- SNOOZE_SEC, 300: snooze duration in seconds; legal range 1–511.
- RING_TIMEOUT_SEC, 60: seconds of continuous ringing before automatic stop; legal range 1–255.
- TONE_DIV, 25000: clk cycles per buzzer half-period; used only with ALARM_TONE_EN.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick_1hz  in  1  one-clk-cycle pulse, once per second.
- alarm_en  in  1  alarm armed (level).
- snooze  in  1  one-cycle debounced button pulse.
- stop  in  1  one-cycle debounced button pulse.
- time_hourMSB, time_hourLSB, time_minMSB, time_minLSB, time_secMSB, time_secLSB  in  4 each  current-time BCD digits.
- alarm_hourMSB, alarm_hourLSB, alarm_minMSB, alarm_minLSB, alarm_secMSB, alarm_secLSB  in  4 each  alarm-time BCD digits.
- buzz  out  1  buzzer drive.
- ringing  out  1  high in RINGING.
- snoozing  out  1  high in SNOOZE.
- snooze_left  out  9  seconds remaining in SNOOZE; 0 otherwise.

## Operation
- match = all 24 time bits equal all 24 alarm bits (raw compare, no BCD validation). match_q registers match every cycle; match_rise = match & ~match_q.
- States: IDLE, RINGING, SNOOZE. Registered state; ringing and snoozing are decoded from it.
- IDLE: match_rise & alarm_en -> RINGING, ring_cnt := 0. Otherwise stay.
- RINGING, in priority order: stop -> IDLE; ~alarm_en -> IDLE; snooze -> SNOOZE with snooze_left := SNOOZE_SEC; on tick_1hz, if ring_cnt == RING_TIMEOUT_SEC-1 -> IDLE, else ring_cnt += 1.
- SNOOZE, in priority order: stop -> IDLE; ~alarm_en -> IDLE; on tick_1hz, if snooze_left == 1 -> RINGING with ring_cnt := 0 and snooze_left := 0, else snooze_left -= 1.
- In RINGING and SNOOZE, match_rise is ignored and does not restart ring_cnt.
- snooze in IDLE or SNOOZE is ignored. stop in IDLE is ignored.
- snooze_left is forced to 0 on every entry to IDLE.
- Widths: ring_cnt is 8 bits, snooze_left is 9 bits; neither counter wraps.

## Timing
- Reset values: state IDLE, buzz 0, ringing 0, snoozing 0, snooze_left 0, ring_cnt 0, tone phase 0.
- match_q resets to 1, so an equality present when reset releases does not ring.
- Latency: if time first equals alarm in cycle N (match_q = 0), ringing = 1 in cycle N+1.
- Button latency: stop or snooze sampled in cycle N changes state and outputs in cycle N+1.
- Same-cycle events follow the priority order above. Examples: stop + snooze in RINGING -> IDLE; snooze + final timeout tick -> SNOOZE.
- Reset mid-ring or mid-snooze returns to IDLE in the next cycle. An alarm reached again later rings normally after match_q sees a non-match.

## Configuration
- ALARM_TONE_EN defined: a tone counter runs only in RINGING and is cleared outside it. tone toggles every TONE_DIV cycles. buzz = ringing & tone, so first sound begins TONE_DIV cycles after entry to RINGING.
- ALARM_TONE_EN undefined: buzz = ringing (steady). The tone counter is not built and TONE_DIV is unused.

## Test plan
- Ring then timeout: alarm 07:00:00, alarm_en=1, time steps 06:59:59 -> 07:00:00 -> ringing=1 next cycle. After 60 tick_1hz pulses (RING_TIMEOUT_SEC=60) -> IDLE with buzz=0.
- Snooze cycle: in RINGING, pulse snooze -> snoozing=1, snooze_left=300. After 299 ticks snooze_left=1; the next tick -> ringing=1, snooze_left=0.
- Stop priority: stop and snooze in the same cycle while RINGING -> IDLE; snoozing stays 0.
- Disarm: drop alarm_en during SNOOZE -> IDLE next cycle, snooze_left=0. Time equal to alarm with alarm_en=0 -> no ring.
- Reset behaviour: reset with time == alarm -> no ring after release. Advance time away and back to the alarm -> rings. Reset asserted mid-ring -> all outputs 0 next cycle.
- Tone (ALARM_TONE_EN, TONE_DIV=4): in RINGING, buzz is 0 for 4 cycles, then 1 for 4 cycles, repeating. Without the macro, buzz equals ringing every cycle.
